// File: rtl/pipelined_adder.sv
// Pipelined N-bit add/subtract unit: ripple full-adder slices separated by registers,
// valid/ready on both sides. Define PIPELINED_ADDER_OVF_EN to add the out_ovf port.
module pipelined_adder #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout
`ifdef PIPELINED_ADDER_OVF_EN
   ,
   output logic             out_ovf
`endif
);

   localparam int unsigned SW = WIDTH / STAGES;

   if (STAGES == 0 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
      $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
   end

   logic adv;

   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;

   for (genvar k = 0; k < STAGES; k++) begin : g_slice
      localparam int unsigned LO = k * SW;
      // Operand bits not yet consumed by earlier slices (this slice's chunk is the low SW).
      localparam int unsigned RW = WIDTH - LO;

      logic [RW-1:0]    ra, rb;
      logic             cin, vin;
      logic [SW-1:0]    cs;
      logic             cout;
      logic [LO+SW-1:0] s_d, s_q;
      logic             v_q, c_q;

      if (k == 0) begin : g_head
         // Subtract folds into the operands here: effective B and carry-in travel with the beat.
         assign ra  = in_a;
         assign rb  = in_sub ? ~in_b : in_b;
         assign cin = in_sub | in_cin;
         assign vin = in_valid;
         assign s_d = cs;
      end else begin : g_body
         assign ra  = g_slice[k-1].g_fwd.a_q;
         assign rb  = g_slice[k-1].g_fwd.b_q;
         assign cin = g_slice[k-1].c_q;
         assign vin = g_slice[k-1].v_q;
         assign s_d = {cs, g_slice[k-1].s_q};
      end

      always_comb begin
         logic c;
         c  = cin;
         cs = '0;
         for (int i = 0; i < int'(SW); i++) begin
            cs[i] = ra[i] ^ rb[i] ^ c;
            c     = (ra[i] & rb[i]) | (c & (ra[i] ^ rb[i]));
         end
         cout = c;
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            s_q <= '0;
         end else if (adv) begin
            v_q <= vin;
            c_q <= cout;
            s_q <= s_d;
         end
      end

      if (k < STAGES - 1) begin : g_fwd
         logic [RW-SW-1:0] a_q, b_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               a_q <= '0;
               b_q <= '0;
            end else if (adv) begin
               a_q <= ra[RW-1:SW];
               b_q <= rb[RW-1:SW];
            end
         end
      end
   end

   assign out_valid = g_slice[STAGES-1].v_q;
   assign out_sum   = g_slice[STAGES-1].s_q;
   assign out_cout  = g_slice[STAGES-1].c_q;

`ifdef PIPELINED_ADDER_OVF_EN
   logic ovf_q;

   // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (adv) begin
         ovf_q <= g_slice[STAGES-1].ra[SW-1] ^ g_slice[STAGES-1].rb[SW-1]
                ^ g_slice[STAGES-1].cs[SW-1] ^ g_slice[STAGES-1].cout;
      end
   end

   assign out_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder (WIDTH=8).
// Overflow checks run when PIPELINED_ADDER_OVF_EN is defined.
module tb_pipelined_adder;

   localparam int unsigned WIDTH  = 8;
   localparam int unsigned STAGES = 2;

   logic             clk = 1'b0;
   logic             rst, in_valid, in_ready, in_cin, in_sub;
   logic             out_valid, out_ready, out_cout;
   logic [WIDTH-1:0] in_a, in_b, out_sum;
`ifdef PIPELINED_ADDER_OVF_EN
   logic             out_ovf;
   logic             obs_ovf;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] obs_sum;
   logic       obs_cout;
   int         obs_lat;
   bit         obs_ok;

   always #5 clk = ~clk;

   pipelined_adder #(
      .WIDTH (WIDTH),
      .STAGES(STAGES)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_cin   (in_cin),
      .in_sub   (in_sub),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sum  (out_sum),
      .out_cout (out_cout)
`ifdef PIPELINED_ADDER_OVF_EN
      ,
      .out_ovf  (out_ovf)
`endif
   );

   // Issue one beat into an empty pipe and capture the first result (bounded wait).
   task automatic do_beat(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic sub);
      @(negedge clk);
      in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      obs_ok = 1'b0;
      obs_lat = 0;
      for (int n = 1; n <= 4 * int'(STAGES); n++) begin
         if (out_valid) begin
            obs_ok = 1'b1;
            obs_lat = n;
            obs_sum = out_sum;
            obs_cout = out_cout;
`ifdef PIPELINED_ADDER_OVF_EN
            obs_ovf = out_ovf;
`endif
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
      n_checks++;
      if (out_sum !== 8'h00) begin
         n_fail++; $display("FAIL reset_out_sum: got %h want 00", out_sum);
      end
      n_checks++;
      if (out_cout !== 1'b0) begin
         n_fail++; $display("FAIL reset_out_cout: got %b want 0", out_cout);
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
`ifdef PIPELINED_ADDER_OVF_EN
      n_checks++;
      if (out_ovf !== 1'b0) begin
         n_fail++; $display("FAIL reset_out_ovf: got %b want 0", out_ovf);
      end
`endif
   endtask

   task automatic test_latency();
      do_beat(8'h0F, 8'h01, 1'b0, 1'b0);
      n_checks++;
      if (obs_ok !== 1'b1) begin
         n_fail++; $display("FAIL latency_timeout: got no result want result");
      end
      n_checks++;
      if (obs_lat != int'(STAGES)) begin
         n_fail++; $display("FAIL latency_cycles: got %0d want %0d", obs_lat, STAGES);
      end
      n_checks++;
      if (obs_sum !== 8'h10) begin
         n_fail++; $display("FAIL latency_sum: got %h want 10", obs_sum);
      end
      n_checks++;
      if (obs_cout !== 1'b0) begin
         n_fail++; $display("FAIL latency_cout: got %b want 0", obs_cout);
      end
   endtask

   task automatic test_carry();
      do_beat(8'hFF, 8'h01, 1'b0, 1'b0);
      n_checks++;
      if (obs_ok !== 1'b1 || obs_sum !== 8'h00) begin
         n_fail++; $display("FAIL carry_cross_sum: got %h (ok=%b) want 00", obs_sum, obs_ok);
      end
      n_checks++;
      if (obs_cout !== 1'b1) begin
         n_fail++; $display("FAIL carry_cross_cout: got %b want 1", obs_cout);
      end
      do_beat(8'h00, 8'h00, 1'b1, 1'b0);
      n_checks++;
      if (obs_ok !== 1'b1 || obs_sum !== 8'h01) begin
         n_fail++; $display("FAIL carry_cin_sum: got %h (ok=%b) want 01", obs_sum, obs_ok);
      end
      n_checks++;
      if (obs_cout !== 1'b0) begin
         n_fail++; $display("FAIL carry_cin_cout: got %b want 0", obs_cout);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] va[3] = '{8'h05, 8'h10, 8'h07};
      logic [7:0] vb[3] = '{8'h07, 8'h20, 8'h05};
      logic       vs[3] = '{1'b1, 1'b0, 1'b1};
      logic [7:0] es[3] = '{8'hFE, 8'h30, 8'h02};
      logic       ec[3] = '{1'b0, 1'b0, 1'b1};
      int got = 0;
      int first = -1;
      int last = -1;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 3 + 2 * int'(STAGES) + 4; cyc++) begin
         @(negedge clk);
         if (cyc < 3) begin
            in_a = va[cyc]; in_b = vb[cyc]; in_sub = vs[cyc]; in_cin = 1'b0; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         if (out_valid) begin
            if (got < 3) begin
               n_checks++;
               if (out_sum !== es[got] || out_cout !== ec[got]) begin
                  n_fail++;
                  $display("FAIL b2b_beat%0d: got %h/%b want %h/%b", got, out_sum, out_cout,
                           es[got], ec[got]);
               end
            end
            if (first < 0) first = cyc;
            last = cyc;
            got++;
         end
      end
      n_checks++;
      if (got != 3) begin
         n_fail++; $display("FAIL b2b_count: got %0d want 3", got);
      end
      n_checks++;
      if (last - first != 2) begin
         n_fail++; $display("FAIL b2b_consecutive: got span %0d want 2", last - first);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] va[4] = '{8'h11, 8'hF0, 8'h40, 8'h7E};
      logic [7:0] vb[4] = '{8'h22, 8'h20, 8'h41, 8'h01};
      logic       vc[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic       vs[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic [7:0] es[4] = '{8'h33, 8'h10, 8'hFF, 8'h80};
      logic       ec[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      int sent = 0;
      int got = 0;
      int extra = 0;
      bit holding = 1'b0;
      logic [7:0] held = '0;
      for (int cyc = 0; cyc < 60; cyc++) begin
         @(negedge clk);
         out_ready = (cyc >= 5);
         if (sent < 4) begin
            in_a = va[sent]; in_b = vb[sent]; in_cin = vc[sent]; in_sub = vs[sent];
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (out_valid && !out_ready) begin
            n_checks++;
            if (in_ready !== 1'b0) begin
               n_fail++; $display("FAIL bp_in_ready_full: got %b want 0", in_ready);
            end
            if (holding) begin
               n_checks++;
               if (out_sum !== held) begin
                  n_fail++; $display("FAIL bp_sum_stable: got %h want %h", out_sum, held);
               end
            end
            held = out_sum;
            holding = 1'b1;
         end
         if (out_valid && out_ready) begin
            n_checks++;
            if (got >= 4 || out_sum !== es[got & 3] || out_cout !== ec[got & 3]) begin
               n_fail++;
               $display("FAIL bp_beat%0d: got %h/%b want %h/%b", got, out_sum, out_cout,
                        es[got & 3], ec[got & 3]);
            end
            got++;
         end
         if (in_valid && in_ready) sent++;
         if (got >= 4) break;
      end
      n_checks++;
      if (got != 4) begin
         n_fail++; $display("FAIL bp_count: got %0d want 4", got);
      end
      in_valid = 1'b0;
      for (int cyc = 0; cyc < 2 * int'(STAGES) + 2; cyc++) begin
         @(negedge clk);
         if (out_valid) extra++;
      end
      n_checks++;
      if (extra != 0) begin
         n_fail++; $display("FAIL bp_duplicate: got %0d extra results want 0", extra);
      end
   endtask

   task automatic test_reset_flush();
      int seen = 0;
      out_ready = 1'b1;
      @(negedge clk);
      in_a = 8'h01; in_b = 8'h01; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_a = 8'h02; in_b = 8'h02;
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL flush_out_valid: got %b want 0", out_valid);
      end
      n_checks++;
      if (out_sum !== 8'h00) begin
         n_fail++; $display("FAIL flush_out_sum: got %h want 00", out_sum);
      end
      for (int cyc = 0; cyc < 2 * int'(STAGES) + 3; cyc++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      n_checks++;
      if (seen != 0) begin
         n_fail++; $display("FAIL flush_stale_beats: got %0d results want 0", seen);
      end
   endtask

`ifdef PIPELINED_ADDER_OVF_EN
   task automatic test_ovf();
      do_beat(8'h7F, 8'h01, 1'b0, 1'b0);
      n_checks++;
      if (obs_ok !== 1'b1 || obs_sum !== 8'h80 || obs_ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_add_pos: got %h ovf=%b want 80 ovf=1", obs_sum, obs_ovf);
      end
      do_beat(8'h80, 8'h01, 1'b0, 1'b1);
      n_checks++;
      if (obs_ok !== 1'b1 || obs_sum !== 8'h7F || obs_ovf !== 1'b1 || obs_cout !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_sub_neg: got %h ovf=%b cout=%b want 7F ovf=1 cout=1", obs_sum,
                  obs_ovf, obs_cout);
      end
      do_beat(8'h01, 8'h01, 1'b0, 1'b0);
      n_checks++;
      if (obs_ok !== 1'b1 || obs_sum !== 8'h02 || obs_ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_none: got %h ovf=%b want 02 ovf=0", obs_sum, obs_ovf);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_latency();
      test_carry();
      test_back_to_back();
      test_backpressure();
      test_reset_flush();
`ifdef PIPELINED_ADDER_OVF_EN
      test_ovf();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
